// File: rtl/tube_fifo_pkg.sv
// Shared constants and width helper for the Tube FIFO family.
// Pure declarations, no logic.
package tube_fifo_pkg;

    localparam logic [7:0] TUBE_EMPTY_VAL = 8'hAA;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/tube_fifo_ram.sv
// Purpose: DEPTH x DATA_W register array, one synchronous write port and one asynchronous read port.
// Latency: a write lands at the clock edge; the read port is combinational.
// Backpressure: none; the caller gates we.
module tube_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 24,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tube_fifo_sync.sv
// Purpose: single-clock parasite-to-host FIFO, any depth >= 2, show-ahead read, optional sticky
// overflow/underflow flags under macro TUBE_FIFO_ERR_EN. Latency: a word written at edge N is on rd_data after edge N.
// Backpressure: writes into a full FIFO are dropped unless a read is accepted in the same cycle; reads while empty are ignored.
module tube_fifo_sync
    import tube_fifo_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 24,
    parameter logic [DATA_W-1:0] EMPTY_VAL = DATA_W'(TUBE_EMPTY_VAL),
    parameter int                AF_THRESH = 23,
    localparam int               LVL_W     = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              data_available,
    output logic [LVL_W-1:0]  level
`ifdef TUBE_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              empty;
    logic              acc_wr;
    logic              acc_rd;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (level_q == '0);
    assign acc_rd = rd_en & ~empty;
    assign acc_wr = wr_en & (~full | acc_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (acc_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (acc_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({acc_wr, acc_rd})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    tube_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (acc_wr & ~flush),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // All flags derive from the registered level only.
    assign level          = level_q;
    assign full           = (level_q == LVL_W'(DEPTH));
    assign almost_full    = (level_q >= LVL_W'(AF_THRESH));
    assign data_available = ~empty;
    assign rd_data        = empty ? EMPTY_VAL : ram_rdata;

`ifdef TUBE_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~rd_en) overflow  <= 1'b1;
            if (rd_en & empty)         underflow <= 1'b1;
        end
    end
`else
    // Dropped writes and ignored reads are silent in this build.
`endif

endmodule
